// File: rtl/draw_line_seq_pkg.sv
// Shared types and the fixed cube edge list for the line-job sequencer.
package draw_line_seq_pkg;

    localparam int unsigned VERT_W     = 3;
    localparam int unsigned N_EDGE_TBL = 12;

    typedef struct packed {
        logic [VERT_W-1:0] a;
        logic [VERT_W-1:0] b;
    } edge_t;

    // Bottom face, top face, then the four verticals.
    localparam edge_t EDGE_TABLE [N_EDGE_TBL] = '{
        '{a: 3'd0, b: 3'd1}, '{a: 3'd1, b: 3'd2}, '{a: 3'd2, b: 3'd3}, '{a: 3'd3, b: 3'd0},
        '{a: 3'd4, b: 3'd5}, '{a: 3'd5, b: 3'd6}, '{a: 3'd6, b: 3'd7}, '{a: 3'd7, b: 3'd4},
        '{a: 3'd0, b: 3'd4}, '{a: 3'd1, b: 3'd5}, '{a: 3'd2, b: 3'd6}, '{a: 3'd3, b: 3'd7}
    };

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_B  = 3'd2,
        CAP_B = 3'd3,
        START = 3'd4,
        WAIT  = 3'd5
    } seq_state_t;

    // Range-safe table lookup; out-of-range indices return vertex pair 0-0.
    function automatic edge_t edge_at(input int unsigned idx);
        edge_t e;
        e = '0;
        for (int unsigned k = 0; k < N_EDGE_TBL; k++) begin
            if (idx == k) e = EDGE_TABLE[k];
        end
        return e;
    endfunction

endpackage

// File: rtl/draw_line_seq.sv
// Walks the cube edge list, fetches both endpoints and issues one draw_line job per edge.
// Optional: DRAW_LINE_SEQ_SKIP_DEGEN_EN skips zero-length edges instead of issuing them.
module draw_line_seq
    import draw_line_seq_pkg::*;
#(
    parameter int unsigned XY_BITW = 16,
    parameter int unsigned N_VERT  = 8,
    parameter int unsigned N_EDGE  = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_start,
    input  logic                        abort,
    output logic [$clog2(N_VERT)-1:0]   vert_idx,
    input  logic [XY_BITW-1:0]          vert_x,
    input  logic [XY_BITW-1:0]          vert_y,
    input  logic                        pix_ready,
    output logic                        start,
    output logic                        oe,
    output logic [XY_BITW-1:0]          x0,
    output logic [XY_BITW-1:0]          y0,
    output logic [XY_BITW-1:0]          x1,
    output logic [XY_BITW-1:0]          y1,
    input  logic                        drawing,
    input  logic                        done,
    output logic [$clog2(N_EDGE)-1:0]   edge_idx,
    output logic                        busy,
    output logic                        frame_done
);

    localparam int unsigned VIDX_W = $clog2(N_VERT);
    localparam int unsigned EIDX_W = $clog2(N_EDGE);

    seq_state_t          state, state_nxt;
    logic [EIDX_W-1:0]   edge_idx_nxt;
    logic [VIDX_W-1:0]   vert_idx_nxt;
    logic [XY_BITW-1:0]  x0_nxt, y0_nxt, x1_nxt, y1_nxt;
    logic                start_nxt, frame_done_nxt;
    logic                last_edge, degen, job_end;
    edge_t               sel_edge;

    // drawing is status only; sequencing relies solely on done.
    logic unused_drawing;
    assign unused_drawing = drawing;

`ifdef DRAW_LINE_SEQ_SKIP_DEGEN_EN
    assign degen = (vert_x == x0) && (vert_y == y0);
`else
    assign degen = 1'b0;
`endif

    assign last_edge = (edge_idx == EIDX_W'(N_EDGE - 1));
    assign job_end   = ((state == WAIT) && done) || ((state == CAP_B) && degen);

    // Only path by which draw_line stalls, so it stays combinational.
    assign oe = (state == WAIT) && pix_ready;

    // Next-state and registered-output decode.
    always_comb begin
        state_nxt      = state;
        edge_idx_nxt   = edge_idx;
        x0_nxt         = x0;
        y0_nxt         = y0;
        x1_nxt         = x1;
        y1_nxt         = y1;
        start_nxt      = 1'b0;
        frame_done_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (frame_start) begin
                    edge_idx_nxt = '0;
                    state_nxt    = RD_A;
                end
            end
            RD_A:  state_nxt = RD_B;
            RD_B: begin
                x0_nxt    = vert_x;
                y0_nxt    = vert_y;
                state_nxt = CAP_B;
            end
            CAP_B: begin
                x1_nxt = vert_x;
                y1_nxt = vert_y;
                if (!degen) begin
                    start_nxt = 1'b1;
                    state_nxt = START;
                end
            end
            START: state_nxt = WAIT;
            WAIT:  state_nxt = WAIT;
            default: state_nxt = IDLE;
        endcase

        // Shared finish/advance rule for a completed or skipped edge.
        if (job_end) begin
            if (last_edge) begin
                frame_done_nxt = 1'b1;
                state_nxt      = IDLE;
            end else begin
                edge_idx_nxt = edge_idx + EIDX_W'(1);
                state_nxt    = RD_A;
            end
        end

        if (abort && (state != IDLE)) begin
            state_nxt      = IDLE;
            edge_idx_nxt   = edge_idx;
            start_nxt      = 1'b0;
            frame_done_nxt = 1'b0;
        end
    end

    // Vertex address is issued as the read state is entered so data lands one cycle later.
    always_comb begin
        sel_edge     = edge_at(32'(edge_idx_nxt));
        vert_idx_nxt = vert_idx;
        if (state_nxt == RD_A) vert_idx_nxt = VIDX_W'(sel_edge.a);
        if (state_nxt == RD_B) vert_idx_nxt = VIDX_W'(sel_edge.b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            edge_idx   <= '0;
            vert_idx   <= '0;
            x0         <= '0;
            y0         <= '0;
            x1         <= '0;
            y1         <= '0;
            start      <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            edge_idx   <= edge_idx_nxt;
            vert_idx   <= vert_idx_nxt;
            x0         <= x0_nxt;
            y0         <= y0_nxt;
            x1         <= x1_nxt;
            y1         <= y1_nxt;
            start      <= start_nxt;
            frame_done <= frame_done_nxt;
            busy       <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_draw_line_seq.sv
// Bench for draw_line_seq: per-cycle comparison against a schedule planned from the edge list.
module tb_draw_line_seq;

    localparam int MAXC = 128;
`ifdef DRAW_LINE_SEQ_SKIP_DEGEN_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, frame_start, abort, pix_ready, done, drawing;
    logic [2:0]  vert_idx;
    logic [15:0] vert_x, vert_y, x0, y0, x1, y1;
    logic [3:0]  edge_idx;
    logic        start, oe, busy, frame_done;

    always #5 clk = ~clk;

    draw_line_seq dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .abort(abort),
        .vert_idx(vert_idx), .vert_x(vert_x), .vert_y(vert_y), .pix_ready(pix_ready),
        .start(start), .oe(oe), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .drawing(drawing), .done(done), .edge_idx(edge_idx), .busy(busy),
        .frame_done(frame_done)
    );

    int ea [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3};
    int eb [12] = '{1, 2, 3, 0, 5, 6, 7, 4, 4, 5, 6, 7};
    logic [15:0] vx [8];
    logic [15:0] vy [8];

    int cyc = 0;
    int n_checks = 0, n_err = 0;

    // Vertex store with one cycle read latency.
    always @(posedge clk) begin
        vert_x <= vx[vert_idx];
        vert_y <= vy[vert_idx];
    end

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    // draw_line stand-in: done three cycles after each start; optional abort on a chosen job's done.
    int done_at = -1, jobs_seen = 0, abort_job = -1;
    always @(negedge clk) begin
        if (rst) begin
            done_at   = -1;
            jobs_seen = 0;
        end else if (start) begin
            done_at   = cyc + 3;
            jobs_seen = jobs_seen + 1;
        end
    end
    always @(posedge clk) begin
        #1;
        done    = !rst && (cyc == done_at);
        abort   = done && (abort_job >= 0) && (jobs_seen == abort_job + 1);
        drawing = (done_at > cyc);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Expected schedule, indexed by cycle since reset release.
    bit e_busy [MAXC];
    bit e_start[MAXC];
    bit e_fd   [MAXC];
    int e_wj   [MAXC];
    int js     [12];

    task automatic plan(input int fs, input int ab_job);
        int rda, capb, st, dn;
        for (int c = 0; c < MAXC; c++) begin
            e_busy[c] = 0; e_start[c] = 0; e_fd[c] = 0; e_wj[c] = -1;
        end
        for (int k = 0; k < 12; k++) js[k] = -1;
        if (fs < 0) return;
        rda = fs + 1;
        for (int k = 0; k < 12; k++) begin
            capb = rda + 2;
            for (int c = rda; c <= capb; c++) e_busy[c] = 1;
            if (SKIP_EN && vx[ea[k]] == vx[eb[k]] && vy[ea[k]] == vy[eb[k]]) begin
                if (k == 11) e_fd[capb + 1] = 1;
                rda = capb + 1;
                continue;
            end
            st = rda + 3;
            dn = st + 3;
            js[k] = st;
            e_start[st] = 1;
            for (int c = st; c <= dn; c++) e_busy[c] = 1;
            for (int c = st + 1; c <= dn; c++) e_wj[c] = k;
            if (k == ab_job) return;
            if (k == 11) e_fd[dn + 1] = 1;
            else rda = dn + 1;
        end
    endtask

    bit checking = 0;
    int n_start, n_fd, first_start, fd_cyc;
    int f_x0, f_y0, f_x1, f_y1;

    // Per-cycle compare against the planned schedule.
    always @(negedge clk) begin
        if (checking && cyc < MAXC) begin
            int c, k;
            c = cyc;
            chk("busy", int'(busy), int'(e_busy[c]));
            chk("start", int'(start), int'(e_start[c]));
            chk("frame_done", int'(frame_done), int'(e_fd[c]));
            chk("oe", int'(oe), int'((e_wj[c] >= 0) && pix_ready));
            if (e_wj[c] >= 0) begin
                k = e_wj[c];
                chk("edge_idx", int'(edge_idx), k);
                chk("x0", int'(x0), int'(vx[ea[k]]));
                chk("y0", int'(y0), int'(vy[ea[k]]));
                chk("x1", int'(x1), int'(vx[eb[k]]));
                chk("y1", int'(y1), int'(vy[eb[k]]));
            end
            if (start) begin
                n_start++;
                if (first_start < 0) begin
                    first_start = c;
                    f_x0 = int'(x0); f_y0 = int'(y0); f_x1 = int'(x1); f_y1 = int'(y1);
                end
            end
            if (frame_done) begin
                n_fd++;
                fd_cyc = c;
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_start"}, int'(start), 0);
        chk({tag, "_oe"}, int'(oe), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_coords"}, int'(x0 | y0 | x1 | y1), 0);
        chk({tag, "_edge_idx"}, int'(edge_idx), 0);
        chk({tag, "_vert_idx"}, int'(vert_idx), 0);
    endtask

    task automatic reset_dut();
        rst = 1'b1; frame_start = 1'b0; pix_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run(input int fs, input int fs2, input int last_cyc);
        n_start = 0; n_fd = 0; first_start = -1; fd_cyc = -1;
        pix_ready = 1'b1;
        checking = 1;
        while (cyc < last_cyc) begin
            @(posedge clk);
            #1;
            frame_start = (cyc == fs) || (cyc == fs2);
            pix_ready   = 1'($urandom_range(0, 1));
        end
        checking = 0;
        frame_start = 1'b0;
    endtask

    task automatic set_cube();
        vx[0] = 10; vy[0] = 10;  vx[1] = 10; vy[1] = 0;
        vx[2] = 0;  vy[2] = 0;   vx[3] = 0;  vy[3] = 10;
        vx[4] = 20; vy[4] = 25;  vx[5] = 20; vy[5] = 15;
        vx[6] = 30; vy[6] = 15;  vx[7] = 30; vy[7] = 25;
    endtask

    initial begin
        abort = 1'b0; done = 1'b0; drawing = 1'b0;
        set_cube();

        // Full frame, frame_start in cycle 5.
        reset_dut();
        check_zero("reset");
        plan(5, -1);
        run(5, -1, 110);
        chk("first_start_cycle", first_start, 9);
        chk("first_x0", f_x0, 10);
        chk("first_y0", f_y0, 10);
        chk("first_x1", f_x1, 10);
        chk("first_y1", f_y1, 0);
        chk("job_count", n_start, 12);
        chk("frame_done_count", n_fd, 1);
        chk("frame_done_cycle", fd_cyc, 90);

        // frame_start while busy in WAIT of edge 3 is ignored.
        reset_dut();
        plan(5, -1);
        run(5, js[3] + 2, 110);
        chk("busy_fs_jobs", n_start, 12);
        chk("busy_fs_frame_done", n_fd, 1);

        // abort coincident with done of edge 5.
        abort_job = 5;
        reset_dut();
        plan(5, 5);
        run(5, -1, 110);
        abort_job = -1;
        chk("abort_jobs", n_start, 6);
        chk("abort_frame_done", n_fd, 0);

        // Vertices 2 and 3 coincide: edge 2 has zero length.
        vx[2] = 4; vy[2] = 4; vx[3] = 4; vy[3] = 4;
        reset_dut();
        plan(5, -1);
        run(5, -1, 110);
        chk("degen_jobs", n_start, SKIP_EN ? 11 : 12);
        chk("degen_frame_done", n_fd, 1);
        set_cube();

        // Asynchronous reset mid-frame, then no stray activity.
        reset_dut();
        plan(5, -1);
        run(5, -1, 30);
        #3 rst = 1'b1;
        #1 check_zero("midreset");
        @(posedge clk);
        #1 rst = 1'b0;
        plan(-1, -1);
        run(-1, -1, 60);
        chk("midreset_frame_done", n_fd, 0);
        chk("midreset_jobs", n_start, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
